conditional_unit: RTL and testbench
===================================

Name: conditional_unit

Overview:
- Execute-stage condition-evaluation block of the SIMD/AES pipelined processor.
- Evaluates the instruction condition (CondExE) from Opcode and the current flags FlagsE.
- Gates the branch, PC-source and write-enable controls with CondExE, and registers the gated controls into the E→M pipeline boundary.
- Holds the architectural NZCV flag register; conditionally updates it from ALUFlags and feeds it back to decode as ALUFlagsD.

Parameters:
- None. All widths are fixed: opcode 6 bits, flags 4 bits {N,Z,C,V} = bits [3:0].

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
PCSrcE  in  1  execute-stage PC-source request
RegWriteE  in  1  execute-stage register-write request
MemWriteE  in  1  execute-stage memory-write request
BranchE  in  1  instruction in execute is a branch
FlagWriteE  in  2  [1] update N,Z; [0] update C,V
Opcode  in  6  execute-stage opcode
FlagsE  in  4  flags used for condition evaluation {N,Z,C,V}
ALUFlags  in  4  flags produced by the ALU this cycle {N,Z,C,V}
ALUFlagsD  out  4  flag register contents, returned to decode
BranchTakenE  out  1  branch taken this cycle (combinational)
PCSrcM  out  1  registered PCSrcE & CondExE
RegWriteM  out  1  registered RegWriteE & CondExE
MemWriteM  out  1  registered MemWriteE & CondExE

Behaviour:
- CondExE (internal, combinational) from Opcode, with N,Z,C,V = FlagsE[3:0]:
  - 001000 BLT: N != V
  - 001001 BGE: N == V
  - 001010 BLE: Z | (N != V)
  - 001011 BCS: C
  - 001100 BEQ: Z
  - 001101 BNE: !Z
  - 001110 BGT: !Z & (N == V)
  - 001111 B (unconditional): 1
  - 000000 NOP: 0
  - every other opcode: 1
- BranchTakenE = BranchE & CondExE. Purely combinational, same cycle, no clock dependency.
- On each rising clk, when rst = 1:
  - PCSrcM <= PCSrcE & CondExE
  - RegWriteM <= RegWriteE & CondExE
  - MemWriteM <= MemWriteE & CondExE
  - Latency is 1 cycle.
- Flag register, updated on each rising clk:
  - If FlagWriteE[1] & CondExE: flags[3:2] <= ALUFlags[3:2].
  - If FlagWriteE[0] & CondExE: flags[1:0] <= ALUFlags[1:0].
  - Otherwise bits hold. Both halves may update in the same cycle.
- ALUFlagsD = flag register, driven directly from the registers. A flag update is visible on ALUFlagsD the cycle after the write.
- Reset (rst = 0, asynchronous): PCSrcM, RegWriteM and MemWriteM clear to 0 and ALUFlagsD clears to 0000 immediately, regardless of clk. These stay at reset values while rst = 0.
- Reset release is synchronous-safe: the first update happens on the first rising clk after rst returns to 1.
- BranchTakenE is not reset-gated; it follows its inputs even during reset.
- No stalls or handshakes. Inputs are sampled every cycle.
- Unknown/X opcodes are not required to be handled.

Test Plan:
- Branch taken: rst=1; Opcode=001100, BranchE=1, PCSrcE=RegWriteE=MemWriteE=1, FlagsE=0100 -> BranchTakenE=1 at once; after next clk edge PCSrcM=RegWriteM=MemWriteM=1.
- Branch not taken: same stimulus but FlagsE=0000 -> BranchTakenE=0; after edge PCSrcM=RegWriteM=MemWriteM=0.
- BGT: Opcode=001110, FlagsE=0000, BranchE=1, all E controls 1 -> BranchTakenE=1, M outputs 1 after edge. With FlagsE=1000 (N=1, V=0) -> all 0.
- Unconditional and NOP:
  - Opcode=001111, any FlagsE -> BranchTakenE=1, M outputs 1.
  - Opcode=000000, BranchE=0, E controls 1 -> BranchTakenE=0, M outputs 0 after edge.
- Flag write: Opcode=000001, FlagWriteE=10, ALUFlags=1111 -> after edge ALUFlagsD=1100. Then FlagWriteE=01, ALUFlags=0011 -> ALUFlagsD=1111. With Opcode=000000 and FlagWriteE=11 -> ALUFlagsD unchanged.
- Async reset: drive rst=0 mid-cycle while M outputs=1 and ALUFlagsD=1111 -> all cleared immediately without a clock edge. Release rst -> updates resume on the next rising edge.

Source files
------------

// File: rtl/conditional_unit.sv
// Execute-stage condition evaluation: gates branch/PC/write controls with the
// instruction condition, registers them into the E->M boundary and holds NZCV.
module conditional_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  input  logic [1:0] FlagWriteE,
  input  logic [5:0] Opcode,
  input  logic [3:0] FlagsE,
  input  logic [3:0] ALUFlags,
  output logic [3:0] ALUFlagsD,
  output logic       BranchTakenE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM
);

  logic       cond_ex;
  logic [3:0] flags;

  // Opcodes 001000..001111 are conditional branches; NOP never executes,
  // and every other opcode executes unconditionally.
  function automatic logic eval_cond(input logic [5:0] op, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (op)
      6'b001000: eval_cond = n ^ v;
      6'b001001: eval_cond = ~(n ^ v);
      6'b001010: eval_cond = z | (n ^ v);
      6'b001011: eval_cond = c;
      6'b001100: eval_cond = z;
      6'b001101: eval_cond = ~z;
      6'b001110: eval_cond = ~z & ~(n ^ v);
      6'b001111: eval_cond = 1'b1;
      6'b000000: eval_cond = 1'b0;
      default:   eval_cond = 1'b1;
    endcase
  endfunction

  assign cond_ex      = eval_cond(Opcode, FlagsE);
  assign BranchTakenE = BranchE & cond_ex;

  // E -> M pipeline boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      PCSrcM    <= PCSrcE & cond_ex;
      RegWriteM <= RegWriteE & cond_ex;
      MemWriteM <= MemWriteE & cond_ex;
    end
  end

  // NZ and CV halves update independently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= 4'b0000;
    end else begin
      if (FlagWriteE[1] & cond_ex) flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0] & cond_ex) flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign ALUFlagsD = flags;

endmodule

// File: tb/tb_conditional_unit.sv
// Bench for conditional_unit: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_conditional_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchE;
  logic [1:0] FlagWriteE;
  logic [5:0] Opcode;
  logic [3:0] FlagsE, ALUFlags;
  logic [3:0] ALUFlagsD;
  logic       BranchTakenE, PCSrcM, RegWriteM, MemWriteM;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [3:0] m_flags;
  logic [2:0] m_ctl;

  conditional_unit dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
    .Opcode(Opcode), .FlagsE(FlagsE), .ALUFlags(ALUFlags),
    .ALUFlagsD(ALUFlagsD), .BranchTakenE(BranchTakenE), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM)
  );

  always #5 clk = ~clk;

  // Reference condition from the mnemonic rules
  function automatic bit model_cond(input logic [5:0] op, input logic [3:0] f);
    bit n, z, c, v, lt;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    lt = (n != v);
    if (op == 6'd0) return 1'b0;
    if (op < 6'd8 || op > 6'd15) return 1'b1;
    case (op - 6'd8)
      0: return lt;
      1: return !lt;
      2: return z || lt;
      3: return c;
      4: return z;
      5: return !z;
      6: return !z && !lt;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_flags <= 4'b0000;
      m_ctl   <= 3'b000;
    end else begin
      bit ce;
      ce = model_cond(Opcode, FlagsE);
      m_ctl <= ce ? {PCSrcE, RegWriteE, MemWriteE} : 3'b000;
      m_flags <= {(FlagWriteE[1] && ce) ? ALUFlags[3:2] : m_flags[3:2],
                  (FlagWriteE[0] && ce) ? ALUFlags[1:0] : m_flags[1:0]};
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_flags", ALUFlagsD, m_flags);
      check("model_ctl", {1'b0, PCSrcM, RegWriteM, MemWriteM}, {1'b0, m_ctl});
      check("model_btaken", {3'b0, BranchTakenE},
            {3'b0, BranchE & model_cond(Opcode, FlagsE)});
    end
  end

  task automatic drive(input logic [5:0] op, input logic [3:0] fl, input logic br,
                       input logic [2:0] ctl, input logic [1:0] fw, input logic [3:0] alu);
    Opcode = op; FlagsE = fl; BranchE = br;
    {PCSrcE, RegWriteE, MemWriteE} = ctl;
    FlagWriteE = fw; ALUFlags = alu;
  endtask

  task automatic step_check(input string name, input logic bt, input logic [2:0] m);
    #1 check({name, "_bt"}, {3'b0, BranchTakenE}, {3'b0, bt});
    @(posedge clk); #1;
    check({name, "_m"}, {1'b0, PCSrcM, RegWriteM, MemWriteM}, {1'b0, m});
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(6'd0, 4'd0, 1'b0, 3'b000, 2'b00, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", ALUFlagsD, 4'b0000);
    check("reset_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    cmp_en = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;

    drive(6'b001100, 4'b0100, 1'b1, 3'b111, 2'b00, 4'd0); step_check("beq_taken", 1'b1, 3'b111);
    drive(6'b001100, 4'b0000, 1'b1, 3'b111, 2'b00, 4'd0); step_check("beq_not", 1'b0, 3'b000);
    drive(6'b001110, 4'b0000, 1'b1, 3'b111, 2'b00, 4'd0); step_check("bgt_taken", 1'b1, 3'b111);
    drive(6'b001110, 4'b1000, 1'b1, 3'b111, 2'b00, 4'd0); step_check("bgt_not", 1'b0, 3'b000);
    drive(6'b001111, 4'b1011, 1'b1, 3'b111, 2'b00, 4'd0); step_check("b_uncond", 1'b1, 3'b111);
    drive(6'b000000, 4'b1111, 1'b0, 3'b111, 2'b00, 4'd0); step_check("nop", 1'b0, 3'b000);
    drive(6'b001000, 4'b1000, 1'b1, 3'b101, 2'b00, 4'd0); step_check("blt_taken", 1'b1, 3'b101);

    drive(6'b000001, 4'b0000, 1'b0, 3'b000, 2'b10, 4'b1111);
    @(posedge clk); #1 check("fw_nz", ALUFlagsD, 4'b1100);
    @(negedge clk); #1;
    drive(6'b000001, 4'b0000, 1'b0, 3'b000, 2'b01, 4'b0011);
    @(posedge clk); #1 check("fw_cv", ALUFlagsD, 4'b1111);
    @(negedge clk); #1;
    drive(6'b000000, 4'b0000, 1'b0, 3'b000, 2'b11, 4'b0000);
    @(posedge clk); #1 check("fw_nop_hold", ALUFlagsD, 4'b1111);
    @(negedge clk); #1;

    // Asynchronous reset in the middle of the high phase
    drive(6'b000001, 4'b0000, 1'b0, 3'b111, 2'b00, 4'b0000);
    @(posedge clk); #1 check("pre_rst_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0111);
    #1 rst = 1'b0;
    #1;
    check("async_rst_m", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    check("async_rst_flags", ALUFlagsD, 4'b0000);
    @(negedge clk); #1 rst = 1'b1;
    #2 check("release_hold", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0000);
    @(posedge clk); #1 check("release_resume", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0111);
    @(negedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom);
      drive(op, 4'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), 4'($urandom));
      if ($urandom_range(0, 39) == 0) rst = 1'b0;
      else rst = 1'b1;
      @(negedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
